// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA onto the core clock and derives SCL edge and START/STOP strobes.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Idle bus is high; resetting to 1 avoids spurious edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SCL must be high in both samples, so START/STOP can never coincide with an SCL edge.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file via pointer-then-data transfers.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        core_clk,
  input  logic                        PRESETn,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe_o,
  output logic [8*NUM_REGS-1:0]       regs_o,
  output logic                        wr_strobe_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx_o,
  output logic                        busy_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (core_clk),
    .rst_n    (PRESETn),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shreg;
  logic [7:0]           rx_byte;
  logic                 rw_q;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_inc;
  logic                 last_bit;
  logic                 addr_hit;
  logic                 drive_next;
  logic [7:0]           regs [NUM_REGS];

  assign rx_byte  = {shreg[6:0], sda_s};
  assign last_bit = (bit_cnt == '1);
  assign addr_hit = (rx_byte[7:1] == TARGET_ADDR);
  assign ptr_inc  = ptr + 1'b1;

  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else if (scl_rise) begin
      unique case (state_q)
        ST_ADDR:      if (last_bit) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  state_d = rw_q ? ST_RDATA : ST_PTR;
        ST_PTR:       if (last_bit) state_d = ST_PTR_ACK;
        ST_PTR_ACK:   state_d = ST_WDATA;
        ST_WDATA:     if (last_bit) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: state_d = ST_WDATA;
        ST_RDATA:     if (last_bit) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: state_d = (sda_s == ACK) ? ST_RDATA : ST_IGNORE;
        default:      state_d = state_q;
      endcase
    end
  end

  // The state entered on the rising edge decides what SDA does after the following falling edge.
  always_comb begin
    drive_next = 1'b0;
    unique case (state_q)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: drive_next = 1'b1;
      ST_RDATA:                              drive_next = ~shreg[7];
      default:                               drive_next = 1'b0;
    endcase
  end

  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      rw_q        <= 1'b0;
      ptr         <= '0;
      sda_oe_o    <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_idx_o    <= '0;
      busy_o      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe_o <= 1'b0;
      if (stop_det) begin
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
        bit_cnt  <= '0;
      end else if (start_det) begin
        sda_oe_o <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        if (scl_rise) begin
          unique case (state_q)
            ST_ADDR: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit && addr_hit) begin
                busy_o <= 1'b1;
                rw_q   <= rx_byte[0];
              end
            end
            ST_ADDR_ACK: if (rw_q) shreg <= regs[ptr];
            ST_PTR: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit) ptr <= rx_byte[IDX_W-1:0];
            end
            ST_WDATA: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit) begin
                regs[ptr]   <= rx_byte;
                wr_strobe_o <= 1'b1;
                wr_idx_o    <= ptr;
                ptr         <= ptr_inc;
              end
            end
            ST_RDATA: begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
            ST_RDATA_ACK: begin
              if (sda_s == ACK) begin
                ptr   <= ptr_inc;
                shreg <= regs[ptr_inc];
              end
            end
            default: ;
          endcase
        end
        if (scl_fall) sda_oe_o <= drive_next;
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_o[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed I2C controller bench for i2c_target_regs with immediate-assertion checks.
module tb_i2c_target_regs;

  localparam int HALF = 8;

  logic        core_clk = 1'b0;
  logic        PRESETn  = 1'b0;
  logic        scl      = 1'b1;
  logic        sda_m    = 1'b1;
  logic        sda_bus;
  logic        sda_oe_o;
  logic [63:0] regs_o;
  logic        wr_strobe_o;
  logic [2:0]  wr_idx_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  int         scount  = 0;
  int         oe_cnt  = 0;
  int         busy_cnt = 0;
  logic [2:0] slog [0:63];

  assign sda_bus = sda_m & ~sda_oe_o;

  i2c_target_regs #(
    .TARGET_ADDR(7'h50),
    .NUM_REGS   (8),
    .SYNC_STAGES(2)
  ) dut (
    .core_clk   (core_clk),
    .PRESETn    (PRESETn),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe_o),
    .regs_o     (regs_o),
    .wr_strobe_o(wr_strobe_o),
    .wr_idx_o   (wr_idx_o),
    .busy_o     (busy_o)
  );

  initial forever #20 core_clk = ~core_clk;

  always @(negedge core_clk) begin
    if (wr_strobe_o) begin
      slog[scount % 64] = wr_idx_o;
      scount = scount + 1;
    end
    if (sda_oe_o) oe_cnt = oe_cnt + 1;
    if (busy_o) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic send_start;
    sda_m = 1'b1; scl = 1'b1; cyc(HALF);
    sda_m = 1'b0; cyc(HALF);
    scl = 1'b0; cyc(2);
  endtask

  task automatic send_rstart;
    sda_m = 1'b1; cyc(HALF);
    scl = 1'b1; cyc(HALF);
    sda_m = 1'b0; cyc(HALF);
    scl = 1'b0; cyc(2);
  endtask

  task automatic send_stop;
    sda_m = 1'b0; cyc(HALF);
    scl = 1'b1; cyc(HALF);
    sda_m = 1'b1; cyc(HALF);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; cyc(HALF);
    scl = 1'b1; cyc(HALF/2);
    s = sda_bus; cyc(HALF/2);
    scl = 1'b0; cyc(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] data);
    logic s;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      data = {data[6:0], s};
    end
    clk_bit(ack_bit, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s0, oe0, b0;

    cyc(4);
    chk("rst_sda_oe", sda_oe_o, 0);
    chk("rst_regs", regs_o, 0);
    chk("rst_strobe", wr_strobe_o, 0);
    chk("rst_idx", wr_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    PRESETn = 1'b1;
    cyc(4);

    // Plain write: ptr 2, data A5, 3C
    s0 = scount;
    send_start;
    write_byte(8'hA0, ack); chk("w1_addr_ack", ack, 0);
    chk("w1_busy", busy_o, 1);
    write_byte(8'h02, ack); chk("w1_ptr_ack", ack, 0);
    write_byte(8'hA5, ack); chk("w1_d0_ack", ack, 0);
    write_byte(8'h3C, ack); chk("w1_d1_ack", ack, 0);
    send_stop;
    chk("w1_busy_after_stop", busy_o, 0);
    chk("w1_regs", regs_o, 64'h0000_0000_3CA5_0000);
    chk("w1_strobes", scount - s0, 2);
    chk("w1_idx0", slog[s0 % 64], 2);
    chk("w1_idx1", slog[(s0 + 1) % 64], 3);

    // Pointer write, repeated START, read two bytes
    send_start;
    write_byte(8'hA0, ack); chk("r_addr_ack", ack, 0);
    write_byte(8'h02, ack); chk("r_ptr_ack", ack, 0);
    send_rstart;
    write_byte(8'hA1, ack); chk("r_raddr_ack", ack, 0);
    read_byte(1'b0, rd); chk("r_byte0", rd, 8'hA5);
    read_byte(1'b1, rd); chk("r_byte1", rd, 8'h3C);
    cyc(4);
    chk("r_released", sda_oe_o, 0);
    send_stop;

    // Foreign address 0x51
    s0 = scount; oe0 = oe_cnt; b0 = busy_cnt;
    send_start;
    write_byte(8'hA2, ack); chk("na_addr_nack", ack, 1);
    write_byte(8'h00, ack); chk("na_d0_nack", ack, 1);
    write_byte(8'hFF, ack); chk("na_d1_nack", ack, 1);
    send_stop;
    chk("na_oe_never", oe_cnt - oe0, 0);
    chk("na_busy_never", busy_cnt - b0, 0);
    chk("na_strobes", scount - s0, 0);
    chk("na_regs", regs_o, 64'h0000_0000_3CA5_0000);

    // Pointer wrap 7 -> 0
    s0 = scount;
    send_start;
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    write_byte(8'h11, ack); chk("wrap_d0_ack", ack, 0);
    write_byte(8'h22, ack); chk("wrap_d1_ack", ack, 0);
    send_stop;
    chk("wrap_regs", regs_o, 64'h1100_0000_3CA5_0022);
    chk("wrap_idx0", slog[s0 % 64], 7);
    chk("wrap_idx1", slog[(s0 + 1) % 64], 0);

    // Partial byte aborted by STOP, then full write
    s0 = scount;
    send_start;
    write_byte(8'hA0, ack);
    write_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, ack);
    send_stop;
    chk("part_no_strobe", scount - s0, 0);
    chk("part_regs", regs_o, 64'h1100_0000_3CA5_0022);
    send_start;
    write_byte(8'hA0, ack);
    write_byte(8'h01, ack);
    write_byte(8'h5A, ack); chk("part_d_ack", ack, 0);
    send_stop;
    chk("part_one_strobe", scount - s0, 1);
    chk("part_idx", slog[s0 % 64], 1);
    chk("part_regs2", regs_o, 64'h1100_0000_3CA5_5A22);

    // Async reset while driving a read bit (regs[0]=22, MSB 0)
    send_start;
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    send_rstart;
    write_byte(8'hA1, ack);
    cyc(6);
    chk("ar_driving", sda_oe_o, 1);
    #10;
    PRESETn = 1'b0;
    #1;
    chk("ar_oe_released", sda_oe_o, 0);
    chk("ar_regs", regs_o, 0);
    cyc(2);
    scl = 1'b1; sda_m = 1'b1;
    cyc(4);
    PRESETn = 1'b1;
    cyc(4);
    chk("ar_busy", busy_o, 0);
    s0 = scount;
    send_start;
    write_byte(8'hA0, ack); chk("ar_addr_ack", ack, 0);
    write_byte(8'h03, ack);
    write_byte(8'h77, ack);
    send_stop;
    chk("ar_regs_after", regs_o, 64'h0000_0000_7700_0000);
    chk("ar_idx", slog[s0 % 64], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
